aes_gcm_instance_feeder: RTL and testbench
==========================================

# aes_gcm_instance_feeder

Front end of the AES-GCM pipeline that transmits into stage 1. It accepts one GCM instance descriptor (key schedule, pre-counter block J0, block counts, length block) and a stream of AAD then plaintext blocks from the host. It emits one fully populated pipeline beat per cycle, sequencing the phase code, generating the counter blocks with inc32, and inserting bubble beats whenever input data is not available. Downstream stages carry its outputs unchanged except for the AES rounds applied to o_h, o_encrypted_j0 and o_encrypted_cb.

## Interface
- No parameters.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  descriptor valid.
- o_start_ready  out  1  descriptor accepted when i_start && o_start_ready.
- i_key_schedule  in  [0:1407]  expanded AES-128 key schedule, 11 round keys.
- i_j0  in  [0:127]  pre-counter block J0.
- i_aad_blocks  in  [0:15]  number of AAD blocks, 0..65535.
- i_pt_blocks  in  [0:15]  number of plaintext blocks, 0..65535.
- i_instance_size  in  [0:127]  len(A)||len(C) block, in bits.
- i_data_valid  in  1  host data block valid.
- o_data_ready  out  1  a data transfer occurs when i_data_valid && o_data_ready.
- i_data  in  [0:127]  AAD or plaintext block, host-padded.
- o_phase  out  [0:2]  beat type: 0 bubble, 1 init, 2 aad, 3 pt, 4 len.
- o_new_instance  out  1  high on the init beat only.
- o_key_schedule  out  [0:1407]  key schedule of the current instance.
- o_h  out  [0:127]  always 128'b0; the pipeline encrypts it to H.
- o_encrypted_j0  out  [0:127]  J0 of the current instance.
- o_encrypted_cb  out  [0:127]  counter block for pt beats, else 0.
- o_plain_text  out  [0:127]  i_data on pt beats, else 0.
- o_aad  out  [0:127]  i_data on aad beats, else 0.
- o_instance_size  out  [0:127]  length block on the len beat, else 0.

## Operation
- FSM states: IDLE, AAD, PT, LEN. All outputs are registered.
- o_start_ready = (state == IDLE). o_data_ready = (state == AAD || state == PT).
- Start accept in IDLE:
  - Latch key schedule, J0, counts and length block.
  - Emit an init beat: phase 1, new_instance 1, all data fields 0.
  - Load cb = inc32(J0).
  - Next state: AAD if aad_blocks > 0; else PT if pt_blocks > 0; else LEN.
- AAD: each transfer emits phase 2 with o_aad = i_data and decrements the AAD count. After the last AAD block, go to PT if pt_blocks > 0, else LEN.
- PT: each transfer emits phase 3 with o_plain_text = i_data and o_encrypted_cb = cb, then updates cb = inc32(cb). After the last PT block, go to LEN.
- LEN: unconditionally emit phase 4 with o_instance_size = latched length block, then go to IDLE.
- Any cycle without a beat (IDLE without start, or AAD/PT without a transfer) emits a bubble:
  - phase 0, new_instance 0;
  - plain_text, aad, encrypted_cb and instance_size are 0;
  - key_schedule and encrypted_j0 hold their values.
- inc32: the low 32 bits increment modulo 2^32; the upper 96 bits never change.
- During an instance, o_key_schedule and o_encrypted_j0 stay constant on every beat, bubbles included.
- Descriptor inputs are ignored outside an accepted start. i_data is ignored unless a transfer occurs.

## Timing
- Reset: state IDLE; every output 0, except o_start_ready = 1 and o_data_ready = 0 from the first cycle after the reset edge.
- Reset mid-instance: the instance is discarded, latched counts are cleared, and the next output beat is a bubble.
- Latency: a start or data transfer at edge t appears on the outputs in the cycle following edge t (1 cycle).
- Throughput: 1 beat per cycle. An instance with A AAD and P PT blocks and no stalls occupies exactly A + P + 2 beats. The next start can be accepted on the edge after the len beat is issued.
- A start cannot overlap a running instance, since o_start_ready is 0 outside IDLE.
- rst has priority over start and data transfers arriving in the same cycle.

## Test plan
- Basic instance: J0 = {96'hA, 32'h1}, AAD = 1, PT = 2, data always valid.
  - Required beats: init, aad, pt (cb low word 0x2), pt (cb 0x3), len. No gaps.
  - o_new_instance high only on the init beat.
- Zero AAD, PT = 1 -> beats are init, pt, len.
- AAD = 0 and PT = 0 -> init then len; o_start_ready is high again on the cycle after the len beat.
- Counter wrap: J0 low word 0xFFFFFFFE, PT = 3 -> cb low words 0xFFFFFFFF, 0x00000000, 0x00000001, with upper 96 bits unchanged.
- Backpressure: i_data_valid toggled 1,0,0,1 with PT = 2 -> bubbles (phase 0, key/J0 held) between the two pt beats; cb is not advanced by the bubbles.
- Reset after 1 of 3 PT blocks -> outputs 0 and o_start_ready = 1. A fresh start is then accepted and produces a correct init beat.

Source files
------------

// File: rtl/aes_gcm_instance_feeder.sv
// AES-GCM pipeline front end: turns one instance descriptor plus host AAD/PT
// blocks into a stream of fully populated stage-1 beats.
module aes_gcm_instance_feeder (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_start_ready,
    input  logic [0:1407] i_key_schedule,
    input  logic [0:127]  i_j0,
    input  logic [0:15]   i_aad_blocks,
    input  logic [0:15]   i_pt_blocks,
    input  logic [0:127]  i_instance_size,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    input  logic [0:127]  i_data,
    output logic [0:2]    o_phase,
    output logic          o_new_instance,
    output logic [0:1407] o_key_schedule,
    output logic [0:127]  o_h,
    output logic [0:127]  o_encrypted_j0,
    output logic [0:127]  o_encrypted_cb,
    output logic [0:127]  o_plain_text,
    output logic [0:127]  o_aad,
    output logic [0:127]  o_instance_size
);

    typedef enum logic [1:0] {S_IDLE, S_AAD, S_PT, S_LEN} state_t;

    localparam logic [0:2] PH_BUBBLE = 3'd0;
    localparam logic [0:2] PH_INIT   = 3'd1;
    localparam logic [0:2] PH_AAD    = 3'd2;
    localparam logic [0:2] PH_PT     = 3'd3;
    localparam logic [0:2] PH_LEN    = 3'd4;

    state_t        state, state_n;
    logic [15:0]   aad_cnt, aad_cnt_n;
    logic [15:0]   pt_cnt, pt_cnt_n;
    logic [0:127]  cb, cb_n;
    logic [0:127]  size_q, size_n;
    logic [0:1407] key_n;
    logic [0:127]  j0_n;
    logic [0:2]    phase_n;
    logic          new_n;
    logic [0:127]  ecb_n, pt_n, aad_n, isz_n;
    logic          xfer;

    // Only the low 32-bit word counts; the 96-bit IV part is never carried into.
    function automatic logic [0:127] inc32(input logic [0:127] b);
        return {b[0:95], b[96:127] + 32'd1};
    endfunction

    assign o_start_ready = (state == S_IDLE);
    assign o_data_ready  = (state == S_AAD) || (state == S_PT);
    assign xfer          = i_data_valid && o_data_ready;
    assign o_h           = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            aad_cnt         <= '0;
            pt_cnt          <= '0;
            cb              <= '0;
            size_q          <= '0;
            o_key_schedule  <= '0;
            o_encrypted_j0  <= '0;
            o_phase         <= PH_BUBBLE;
            o_new_instance  <= 1'b0;
            o_encrypted_cb  <= '0;
            o_plain_text    <= '0;
            o_aad           <= '0;
            o_instance_size <= '0;
        end else begin
            state           <= state_n;
            aad_cnt         <= aad_cnt_n;
            pt_cnt          <= pt_cnt_n;
            cb              <= cb_n;
            size_q          <= size_n;
            o_key_schedule  <= key_n;
            o_encrypted_j0  <= j0_n;
            o_phase         <= phase_n;
            o_new_instance  <= new_n;
            o_encrypted_cb  <= ecb_n;
            o_plain_text    <= pt_n;
            o_aad           <= aad_n;
            o_instance_size <= isz_n;
        end
    end

    always_comb begin
        state_n   = state;
        aad_cnt_n = aad_cnt;
        pt_cnt_n  = pt_cnt;
        cb_n      = cb;
        size_n    = size_q;
        key_n     = o_key_schedule;
        j0_n      = o_encrypted_j0;
        phase_n   = PH_BUBBLE;
        new_n     = 1'b0;
        ecb_n     = '0;
        pt_n      = '0;
        aad_n     = '0;
        isz_n     = '0;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    key_n     = i_key_schedule;
                    j0_n      = i_j0;
                    aad_cnt_n = i_aad_blocks;
                    pt_cnt_n  = i_pt_blocks;
                    size_n    = i_instance_size;
                    cb_n      = inc32(i_j0);
                    phase_n   = PH_INIT;
                    new_n     = 1'b1;
                    if (i_aad_blocks != 16'd0)
                        state_n = S_AAD;
                    else if (i_pt_blocks != 16'd0)
                        state_n = S_PT;
                    else
                        state_n = S_LEN;
                end
            end
            S_AAD: begin
                if (xfer) begin
                    phase_n   = PH_AAD;
                    aad_n     = i_data;
                    aad_cnt_n = aad_cnt - 16'd1;
                    if (aad_cnt == 16'd1)
                        state_n = (pt_cnt != 16'd0) ? S_PT : S_LEN;
                end
            end
            S_PT: begin
                if (xfer) begin
                    phase_n  = PH_PT;
                    pt_n     = i_data;
                    ecb_n    = cb;
                    cb_n     = inc32(cb);
                    pt_cnt_n = pt_cnt - 16'd1;
                    if (pt_cnt == 16'd1)
                        state_n = S_LEN;
                end
            end
            S_LEN: begin
                phase_n = PH_LEN;
                isz_n   = size_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_gcm_instance_feeder.sv
// Randomized bench for aes_gcm_instance_feeder: each instance is expanded
// into its expected beat list and compared cycle by cycle against the DUT.
module tb_aes_gcm_instance_feeder;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          o_start_ready;
    logic [0:1407] i_key_schedule;
    logic [0:127]  i_j0;
    logic [0:15]   i_aad_blocks;
    logic [0:15]   i_pt_blocks;
    logic [0:127]  i_instance_size;
    logic          i_data_valid;
    logic          o_data_ready;
    logic [0:127]  i_data;
    logic [0:2]    o_phase;
    logic          o_new_instance;
    logic [0:1407] o_key_schedule;
    logic [0:127]  o_h;
    logic [0:127]  o_encrypted_j0;
    logic [0:127]  o_encrypted_cb;
    logic [0:127]  o_plain_text;
    logic [0:127]  o_aad;
    logic [0:127]  o_instance_size;

    int vectors = 0;
    int miscompares = 0;

    aes_gcm_instance_feeder dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .o_start_ready(o_start_ready),
        .i_key_schedule(i_key_schedule), .i_j0(i_j0),
        .i_aad_blocks(i_aad_blocks), .i_pt_blocks(i_pt_blocks),
        .i_instance_size(i_instance_size),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .i_data(i_data),
        .o_phase(o_phase), .o_new_instance(o_new_instance),
        .o_key_schedule(o_key_schedule), .o_h(o_h),
        .o_encrypted_j0(o_encrypted_j0), .o_encrypted_cb(o_encrypted_cb),
        .o_plain_text(o_plain_text), .o_aad(o_aad),
        .o_instance_size(o_instance_size)
    );

    always #5 clk = ~clk;

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [0:1407] rndkey();
        logic [0:1407] k;
        for (int i = 0; i < 44; i++) k[i*32 +: 32] = $urandom();
        return k;
    endfunction

    function automatic logic [0:127] kfold(input logic [0:1407] k);
        logic [0:127] f = '0;
        for (int i = 0; i < 11; i++) f ^= k[i*128 +: 128];
        return f;
    endfunction

    task automatic scramble_descriptor();
        i_key_schedule  = rndkey();
        i_j0            = rnd128();
        i_aad_blocks    = 16'($urandom());
        i_pt_blocks     = 16'($urandom());
        i_instance_size = rnd128();
    endtask

    task automatic test_reset();
        i_start = 1'b1;
        i_data_valid = 1'b1;
        scramble_descriptor();
        i_data = rnd128();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({o_start_ready, o_data_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 10", {o_start_ready, o_data_ready});
        end
        vectors++;
        if ({o_phase, o_new_instance, o_encrypted_cb, o_plain_text, o_aad,
             o_instance_size, o_encrypted_j0, o_h} !== '0 || o_key_schedule !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: phase %0d j0 %h key fold %h want all 0",
                     o_phase, o_encrypted_j0, kfold(o_key_schedule));
        end
        @(negedge clk);
        rst = 1'b0;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({o_phase, o_new_instance, o_encrypted_cb, o_plain_text, o_aad,
             o_instance_size} !== '0 || o_start_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_bubble: phase %0d ready %b want 0/1", o_phase, o_start_ready);
        end
    endtask

    // vlen == 0 gives random stalls; otherwise valid follows vpat[i % vlen].
    task automatic run_instance(input string nm, input int a, input int p,
                                input logic [0:127] j0, input logic [15:0] vpat,
                                input int vlen, input int abort_after);
        logic [0:1407] key = rndkey();
        logic [0:127]  size = rnd128();
        int issued = 0;
        int total = a + p + 2;
        int dcyc = 0;
        int budget = 300;
        bit need;
        logic v;
        logic [0:127] d;
        logic [0:2] eph;
        logic en;
        logic [0:127] ecb, ept, eaad, esz;
        logic [31:0] lo;

        @(negedge clk);
        vectors++;
        if (o_start_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start_ready: got %b want 1", nm, o_start_ready);
        end
        i_start = 1'b1;
        i_key_schedule = key;
        i_j0 = j0;
        i_aad_blocks = 16'(a);
        i_pt_blocks = 16'(p);
        i_instance_size = size;
        i_data_valid = 1'($urandom());
        i_data = rnd128();
        @(posedge clk);
        #1;
        issued = 1;
        vectors++;
        if ({o_phase, o_new_instance, o_encrypted_cb, o_plain_text, o_aad,
             o_instance_size} !== {3'd1, 1'b1, 512'd0}) begin
            miscompares++;
            $display("FAIL %s init_beat: phase %0d new %b cb %h want 1 1 0",
                     nm, o_phase, o_new_instance, o_encrypted_cb);
        end
        vectors++;
        if (o_key_schedule !== key || o_encrypted_j0 !== j0 || o_h !== '0) begin
            miscompares++;
            $display("FAIL %s init_ctx: key fold %h j0 %h want %h %h",
                     nm, kfold(o_key_schedule), o_encrypted_j0, kfold(key), j0);
        end

        while (issued < total && budget > 0) begin
            budget--;
            @(negedge clk);
            need = (issued <= a + p);
            vectors++;
            if ({o_start_ready, o_data_ready} !== {1'b0, need}) begin
                miscompares++;
                $display("FAIL %s ready: got %b want %b",
                         nm, {o_start_ready, o_data_ready}, {1'b0, need});
            end
            v = (vlen == 0) ? 1'($urandom_range(0, 3) != 0) : vpat[dcyc % vlen];
            if (need) dcyc++;
            d = rnd128();
            i_start = 1'($urandom());
            scramble_descriptor();
            i_data_valid = v;
            i_data = d;
            if (issued == abort_after) begin
                rst = 1'b1;
                i_data_valid = 1'b1;
                @(posedge clk);
                #1;
                vectors++;
                if ({o_phase, o_new_instance, o_encrypted_cb, o_plain_text, o_aad,
                     o_instance_size, o_encrypted_j0} !== '0 || o_key_schedule !== '0 ||
                    {o_start_ready, o_data_ready} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL %s abort_reset: phase %0d cb %h ready %b want 0 0 10",
                             nm, o_phase, o_encrypted_cb, {o_start_ready, o_data_ready});
                end
                @(negedge clk);
                rst = 1'b0;
                i_start = 1'b0;
                i_data_valid = 1'b1;
                @(posedge clk);
                #1;
                vectors++;
                if (o_phase !== 3'd0 || o_start_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s post_reset: phase %0d ready %b want 0 1",
                             nm, o_phase, o_start_ready);
                end
                return;
            end
            @(posedge clk);
            #1;
            eph = 3'd0; en = 1'b0; ecb = '0; ept = '0; eaad = '0; esz = '0;
            if (need && v) begin
                if (issued <= a) begin
                    eph = 3'd2;
                    eaad = d;
                end else begin
                    eph = 3'd3;
                    ept = d;
                    lo = j0[96:127] + 32'(issued - a);
                    ecb = {j0[0:95], lo};
                end
                issued++;
            end else if (!need) begin
                eph = 3'd4;
                esz = size;
                issued++;
            end
            vectors++;
            if ({o_phase, o_new_instance, o_encrypted_cb, o_plain_text, o_aad,
                 o_instance_size} !== {eph, en, ecb, ept, eaad, esz}) begin
                miscompares++;
                $display("FAIL %s beat%0d: phase %0d cb %h pt %h aad %h len %h want %0d %h %h %h %h",
                         nm, issued, o_phase, o_encrypted_cb, o_plain_text, o_aad,
                         o_instance_size, eph, ecb, ept, eaad, esz);
            end
            vectors++;
            if (o_key_schedule !== key || o_encrypted_j0 !== j0 || o_h !== '0) begin
                miscompares++;
                $display("FAIL %s ctx_hold: key fold %h j0 %h want %h %h",
                         nm, kfold(o_key_schedule), o_encrypted_j0, kfold(key), j0);
            end
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL %s timeout: issued %0d want %0d", nm, issued, total);
        end
        vectors++;
        if (o_start_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_after_len: got %b want 1", nm, o_start_ready);
        end
        i_start = 1'b0;
    endtask

    task automatic test_basic();
        run_instance("basic", 1, 2, {96'hA, 32'h1}, 16'hFFFF, 1, -1);
    endtask

    task automatic test_zero_aad();
        run_instance("zero_aad", 0, 1, rnd128(), 16'hFFFF, 1, -1);
    endtask

    task automatic test_empty();
        run_instance("empty", 0, 0, rnd128(), 16'hFFFF, 1, -1);
    endtask

    task automatic test_wrap();
        logic [0:127] j = rnd128();
        j[96:127] = 32'hFFFF_FFFE;
        run_instance("wrap", 0, 3, j, 16'hFFFF, 1, -1);
    endtask

    task automatic test_backpressure();
        run_instance("backpressure", 0, 2, rnd128(), 16'b1001, 4, -1);
    endtask

    task automatic test_reset_mid();
        run_instance("reset_mid", 0, 3, rnd128(), 16'hFFFF, 1, 2);
        run_instance("after_reset", 1, 1, rnd128(), 16'hFFFF, 1, -1);
    endtask

    task automatic test_back_to_back();
        logic [0:127] j;
        for (int i = 0; i < 8; i++) begin
            j = rnd128();
            if (i % 2 == 0) j[96:127] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            run_instance("random", $urandom_range(0, 5), $urandom_range(0, 5), j,
                         16'h0, 0, -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_data_valid = 1'b0;
        i_data = '0;
        scramble_descriptor();
        test_reset();
        test_basic();
        test_zero_aad();
        test_empty();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
